vsqrt_seq: RTL

Vector-to-scalar sequencer directly upstream of the single-element FP16 square-root unit. It accepts one masked vector of FP16 elements from the vector issue stage and feeds the active lanes to the sqrt unit one at a time over its valid/ready handshake. It collects each scalar result back into the matching lane and presents the completed vector to the writeback stage with a valid/ready handshake. Inactive (masked-off) lanes pass the input element through unchanged and are never issued.

---
 rtl/vsqrt_seq_if.sv | 29 ++
 rtl/vsqrt_seq.sv | 111 +++++++++++
 2 files changed

// File: rtl/vsqrt_seq_if.sv
// rtl/vsqrt_seq_if.sv - handshake bundle linking vsqrt_seq to the issue stage, writeback stage and sqrt unit
interface vsqrt_seq_if #(
  parameter int LANES  = 16,
  parameter int DATA_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_vec;
  logic [LANES-1:0]        in_mask;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_vec;
  logic                    sq_valid_data_in;
  logic                    sq_ready;
  logic [DATA_W-1:0]       sq_input_val;
  logic                    sq_valid_data_out;
  logic [DATA_W-1:0]       sq_output_val;
  logic                    busy;

  modport slave (
    input  in_valid, in_vec, in_mask, out_ready, sq_ready, sq_valid_data_out, sq_output_val,
    output in_ready, out_valid, out_vec, sq_valid_data_in, sq_input_val, busy
  );

  modport master (
    output in_valid, in_vec, in_mask, out_ready, sq_ready, sq_valid_data_out, sq_output_val,
    input  in_ready, out_valid, out_vec, sq_valid_data_in, sq_input_val, busy
  );
endinterface

// File: rtl/vsqrt_seq.sv
// rtl/vsqrt_seq.sv - serialises active lanes of a masked FP16 vector through a scalar sqrt unit
module vsqrt_seq #(
  parameter int LANES  = 16,
  parameter int DATA_W = 16
) (
  input logic        CLK,
  input logic        RST,
  vsqrt_seq_if.slave bus
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                  state;
  logic [LANES*DATA_W-1:0] vec_r;
  logic [LANES-1:0]        pend_r;
  logic [LW-1:0]           lane_r;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic                    sq_valid_r;
  logic                    busy_r;
  logic [DATA_W-1:0]       sq_val_r;
  logic [LW-1:0]           cur;
  logic [LANES-1:0]        pend_next;

  function automatic logic [LW-1:0] lowest(input logic [LANES-1:0] m);
    lowest = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) lowest = LW'(i);
    end
  endfunction

  assign cur = lowest(pend_r);

  // pending mask as it will look once the in-flight lane's result is captured
  always_comb begin
    pend_next         = pend_r;
    pend_next[lane_r] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      vec_r       <= '0;
      pend_r      <= '0;
      lane_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      sq_valid_r  <= 1'b0;
      sq_val_r    <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            vec_r      <= bus.in_vec;
            pend_r     <= bus.in_mask;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            if (bus.in_mask == '0) begin
              state       <= DONE;
              out_valid_r <= 1'b1;
            end else begin
              state      <= ISSUE;
              sq_valid_r <= 1'b1;
              sq_val_r   <= bus.in_vec[lowest(bus.in_mask)*DATA_W +: DATA_W];
            end
          end
        end
        ISSUE: begin
          if (bus.sq_ready) begin
            lane_r     <= cur;
            sq_valid_r <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          // operand for the next issue is preloaded so sq_input_val is stable from its first cycle
          if (bus.sq_valid_data_out) begin
            vec_r[lane_r*DATA_W +: DATA_W] <= bus.sq_output_val;
            pend_r                         <= pend_next;
            if (pend_next == '0) begin
              state       <= DONE;
              out_valid_r <= 1'b1;
            end else begin
              state      <= ISSUE;
              sq_valid_r <= 1'b1;
              sq_val_r   <= vec_r[lowest(pend_next)*DATA_W +: DATA_W];
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready         = in_ready_r;
  assign bus.out_valid        = out_valid_r;
  assign bus.out_vec          = vec_r;
  assign bus.sq_valid_data_in = sq_valid_r;
  assign bus.sq_input_val     = sq_val_r;
  assign bus.busy             = busy_r;
endmodule
